// File: rtl/atri_pps_out_generator_pkg.sv
// Shared PPS definitions: state encodings and default timing constants.
// The PPS input path imports the same package so both ends agree on the
// state numbering reported on state_o and on the nominal second length.
package atri_pps_out_generator_pkg;

  typedef enum logic [1:0] {
    ST_FREERUN  = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

  localparam int DEF_PERIOD = 100_000_000;
  localparam int DEF_WINDOW = 1000;

endpackage

// File: rtl/atri_pps_out_generator_phase_detect.sv
// atri_pps_phase_detect: combinational phase comparison of an incoming PPS
// flag against the local second counter.
//   cnt       : current local counter value (0..PERIOD-1)
//   err       : signed two's-complement phase error, positive = input late
//   in_window : |err| <= WINDOW
module atri_pps_phase_detect #(
  parameter int PERIOD   = atri_pps_out_generator_pkg::DEF_PERIOD,
  parameter int CNT_BITS = 27,
  parameter int WINDOW   = atri_pps_out_generator_pkg::DEF_WINDOW
) (
  input  logic [CNT_BITS-1:0] cnt,
  output logic [CNT_BITS-1:0] err,
  output logic                in_window
);

  localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(PERIOD - 1);
  localparam logic [CNT_BITS-1:0] HALF   = CNT_BITS'(PERIOD / 2);
  localparam logic [CNT_BITS-1:0] PER    = CNT_BITS'(PERIOD);
  localparam logic [CNT_BITS-1:0] WIN    = CNT_BITS'(WINDOW);
  localparam logic [CNT_BITS-1:0] WIN_LO = CNT_BITS'(PERIOD - WINDOW);

  logic [CNT_BITS-1:0] d;

  // d is where the counter would be if the flag marked the true second
  // boundary; the upper half of the range folds to negative (early) errors.
  // The window test works on d directly so no signed compare is needed.
  always_comb begin
    d         = (cnt == LAST) ? '0 : cnt + CNT_BITS'(1);
    err       = (d < HALF) ? d : d - PER;
    in_window = (d <= WIN) || (d >= WIN_LO);
  end

endmodule

// File: rtl/atri_pps_out_generator.sv
// atri_pps_out_generator: regenerates a local 1PPS from clk_i and optionally
// disciplines its phase to the single-cycle flag from the PPS input path,
// with acquire, lock, holdover and free-run behaviour.
//   clk_i       : single clock
//   rst_n_i     : asynchronous active-low reset
//   sync_en_i   : enable disciplining to pps_flag_i
//   pps_flag_i  : single-cycle input PPS flag
//   pps_out_o   : regenerated PPS pulse, PULSE_WIDTH cycles high
//   pps_flag_o  : single-cycle flag on the first cycle of each pulse
//   state_o     : FREERUN=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3
//   locked_o    : high while state_o is LOCKED
//   phase_err_o : signed phase error of the last accepted input flag
module atri_pps_out_generator
  import atri_pps_out_generator_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int PULSE_WIDTH  = 10_000_000,
  parameter int CNT_BITS     = 27,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int LOCK_COUNT   = 4,
  parameter int HOLDOVER_MAX = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                sync_en_i,
  input  logic                pps_flag_i,
  output logic                pps_out_o,
  output logic                pps_flag_o,
  output logic [1:0]          state_o,
  output logic                locked_o,
  output logic [CNT_BITS-1:0] phase_err_o
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(HOLDOVER_MAX + 1);

  localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(PERIOD - 1);
  localparam logic [CNT_BITS-1:0] WIN_C  = CNT_BITS'(WINDOW);
  localparam logic [CNT_BITS-1:0] PW_C   = CNT_BITS'(PULSE_WIDTH);
  localparam logic [GOOD_W-1:0]   LOCK_G = GOOD_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]   HMAX_M = MISS_W'(HOLDOVER_MAX);

  pps_state_e          state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic                primed, primed_n;
  logic                seen, seen_n;
  logic [GOOD_W-1:0]   good, good_n;
  logic [MISS_W-1:0]   misses, misses_n;
  logic [CNT_BITS-1:0] err;
  logic                in_window;
  logic                flag, check, realign;

  atri_pps_phase_detect #(
    .PERIOD   (PERIOD),
    .CNT_BITS (CNT_BITS),
    .WINDOW   (WINDOW)
  ) u_phase (
    .cnt       (cnt),
    .err       (err),
    .in_window (in_window)
  );

  // Next-state logic. An accepted flag always realigns the counter, and a
  // flag that realigns is by construction on-phase for the new second, so it
  // also marks the second as seen; otherwise the first miss check after
  // acquiring would always fire. A flag landing on the miss-check cycle
  // takes precedence and suppresses the miss.
  always_comb begin
    flag     = sync_en_i & pps_flag_i;
    check    = (cnt == WIN_C);
    realign  = 1'b0;
    state_n  = state;
    good_n   = good;
    misses_n = misses;
    seen_n   = check ? 1'b0 : seen;

    if (!sync_en_i) begin
      state_n = ST_FREERUN;
    end else if (flag) begin
      realign = 1'b1;
      seen_n  = 1'b1;
      case (state)
        ST_FREERUN: begin
          good_n  = GOOD_W'(1);
          state_n = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (in_window) begin
            good_n = good + GOOD_W'(1);
            if (good + GOOD_W'(1) == LOCK_G) state_n = ST_LOCKED;
          end else begin
            good_n = GOOD_W'(1);
          end
        end
        default: begin
          if (in_window) begin
            state_n = ST_LOCKED;
          end else begin
            good_n  = GOOD_W'(1);
            state_n = ST_ACQUIRE;
          end
        end
      endcase
    end else if (check && !seen) begin
      case (state)
        ST_ACQUIRE: state_n = ST_FREERUN;
        ST_LOCKED: begin
          misses_n = MISS_W'(1);
          state_n  = ST_HOLDOVER;
        end
        ST_HOLDOVER: begin
          misses_n = misses + MISS_W'(1);
          if (misses + MISS_W'(1) == HMAX_M) state_n = ST_FREERUN;
        end
        default: state_n = state;
      endcase
    end

    cnt_n    = (realign || cnt == LAST) ? '0 : cnt + CNT_BITS'(1);
    primed_n = primed | realign | (cnt == LAST);
  end

  // State and counter registers. The pulse outputs are decoded from the
  // next counter value so they line up with cnt while staying registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_FREERUN;
      cnt         <= '0;
      primed      <= 1'b0;
      seen        <= 1'b0;
      good        <= '0;
      misses      <= '0;
      pps_out_o   <= 1'b0;
      pps_flag_o  <= 1'b0;
      locked_o    <= 1'b0;
      phase_err_o <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      primed     <= primed_n;
      seen       <= seen_n;
      good       <= good_n;
      misses     <= misses_n;
      pps_out_o  <= primed_n && (cnt_n < PW_C);
      pps_flag_o <= primed_n && (cnt_n == '0);
      locked_o   <= (state_n == ST_LOCKED);
      if (flag) phase_err_o <= err;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_atri_pps_out_generator.sv
// Self-checking bench for atri_pps_out_generator using small parameters.
// A behavioural model tracks the second counter and the discipline rules
// with plain integer arithmetic and is compared against every output after
// every clock edge, with directed spot checks at the interesting points.
module tb_atri_pps_out_generator;

  localparam int P  = 1000;
  localparam int PW = 100;
  localparam int CB = 10;
  localparam int W  = 5;
  localparam int LC = 3;
  localparam int HM = 2;

  localparam int M_FREERUN  = 0;
  localparam int M_ACQUIRE  = 1;
  localparam int M_LOCKED   = 2;
  localparam int M_HOLDOVER = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_en;
  logic          pps_flag_in;
  logic          pps_out;
  logic          pps_flag_out;
  logic [1:0]    state;
  logic          locked;
  logic [CB-1:0] phase_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int mCnt, mGood, mMisses, mState, mErr;
  bit mPrimed, mSeen;

  always #5 clk = ~clk;

  atri_pps_out_generator #(
    .PERIOD       (P),
    .PULSE_WIDTH  (PW),
    .CNT_BITS     (CB),
    .WINDOW       (W),
    .LOCK_COUNT   (LC),
    .HOLDOVER_MAX (HM)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sync_en_i   (sync_en),
    .pps_flag_i  (pps_flag_in),
    .pps_out_o   (pps_out),
    .pps_flag_o  (pps_flag_out),
    .state_o     (state),
    .locked_o    (locked),
    .phase_err_o (phase_err)
  );

  task automatic modelReset();
    mCnt = 0; mGood = 0; mMisses = 0; mState = M_FREERUN; mErr = 0;
    mPrimed = 0; mSeen = 0;
  endtask

  // One clock edge of the reference behaviour, written from the rules:
  // phase error is the distance to the nearest second boundary.
  task automatic modelEdge(input bit f, input bit s);
    int  d, e;
    bit  inWin, chk, hadSeen, realign;
    d       = (mCnt + 1) % P;
    e       = (d < P / 2) ? d : d - P;
    inWin   = (e <= W) && (e >= -W);
    chk     = (mCnt == W);
    hadSeen = mSeen;
    realign = 0;
    if (chk) mSeen = 0;
    if (!s) begin
      mState = M_FREERUN;
    end else if (f) begin
      realign = 1;
      mSeen   = 1;
      mErr    = e;
      if (mState == M_FREERUN) begin
        mGood = 1; mState = M_ACQUIRE;
      end else if (mState == M_ACQUIRE) begin
        if (inWin) begin
          mGood++;
          if (mGood >= LC) mState = M_LOCKED;
        end else mGood = 1;
      end else if (inWin) begin
        mState = M_LOCKED;
      end else begin
        mGood = 1; mState = M_ACQUIRE;
      end
    end else if (chk && !hadSeen) begin
      if (mState == M_ACQUIRE) mState = M_FREERUN;
      else if (mState == M_LOCKED) begin
        mMisses = 1; mState = M_HOLDOVER;
      end else if (mState == M_HOLDOVER) begin
        mMisses++;
        if (mMisses >= HM) mState = M_FREERUN;
      end
    end
    if (realign || mCnt == P - 1) mPrimed = 1;
    mCnt = realign ? 0 : (mCnt + 1) % P;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [CB-1:0] expErr;
    expErr = mErr[CB-1:0];
    checkValue("pps_out",   32'(pps_out),      32'(mPrimed && mCnt < PW));
    checkValue("pps_flag",  32'(pps_flag_out), 32'(mPrimed && mCnt == 0));
    checkValue("state",     32'(state),        32'(mState));
    checkValue("locked",    32'(locked),       32'(mState == M_LOCKED));
    checkValue("phase_err", 32'(phase_err),    32'(expErr));
  endtask

  // Drive one cycle of inputs, advance the model across the edge and compare.
  task automatic applyStimulus(input bit f, input bit s);
    pps_flag_in = f;
    sync_en     = s;
    @(posedge clk);
    modelEdge(f, s);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s);
  endtask

  task automatic gapFlag(input int gap, input bit s);
    idle(gap - 1, s);
    applyStimulus(1'b1, s);
  endtask

  initial begin
    logic [CB-1:0] e;
    rst_n = 1'b0; sync_en = 1'b0; pps_flag_in = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    // Free-run with random flags that must be ignored while sync is off.
    for (int i = 0; i < 2100; i++) applyStimulus(($urandom_range(0, 149) == 0), 1'b0);
    checkValue("freerun_state", 32'(state), 32'd0);

    // Acquire and lock from an arbitrary phase.
    idle($urandom_range(100, 600), 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkValue("acq_state", 32'(state), 32'd1);
    gapFlag(1000, 1'b1);
    checkValue("acq2_state", 32'(state), 32'd1);
    checkValue("acq2_err", 32'(phase_err), 32'd0);
    gapFlag(1000, 1'b1);
    checkValue("lock_state", 32'(state), 32'd2);
    checkValue("lock_flag_out", 32'(pps_flag_out), 32'd1);
    for (int i = 0; i < 2; i++) gapFlag(1000 + $urandom_range(0, 6) - 3, 1'b1);
    checkValue("jitter_state", 32'(state), 32'd2);

    // Phase error +3 then -4 while locked.
    gapFlag(1003, 1'b1);
    e = 10'(3);
    checkValue("late_err", 32'(phase_err), 32'(e));
    checkValue("late_state", 32'(state), 32'd2);
    checkValue("late_realign", 32'(pps_flag_out), 32'd1);
    gapFlag(996, 1'b1);
    e = 10'(-4);
    checkValue("early_err", 32'(phase_err), 32'(e));
    checkValue("early_state", 32'(state), 32'd2);

    // Glitch at cnt==500 drops back to acquire.
    gapFlag(501, 1'b1);
    e = 10'(-499);
    checkValue("glitch_err", 32'(phase_err), 32'(e));
    checkValue("glitch_state", 32'(state), 32'd1);
    checkValue("glitch_realign", 32'(pps_flag_out), 32'd1);
    gapFlag(1000, 1'b1);
    gapFlag(1000, 1'b1);
    checkValue("relock_state", 32'(state), 32'd2);

    // Flag exactly on the miss-check cycle: out-of-window, no miss.
    gapFlag(6, 1'b1);
    checkValue("edge_state", 32'(state), 32'd1);
    checkValue("edge_err", 32'(phase_err), 32'd6);
    gapFlag(1000, 1'b1);
    checkValue("edge_nomiss", 32'(state), 32'd1);
    gapFlag(1000, 1'b1);
    checkValue("edge_relock", 32'(state), 32'd2);

    // Holdover, recovery, then loss to free-run.
    idle(1006, 1'b1);
    checkValue("hold_state", 32'(state), 32'd3);
    idle(993, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkValue("hold_recover", 32'(state), 32'd2);
    idle(1006, 1'b1);
    checkValue("hold2_state", 32'(state), 32'd3);
    idle(1000, 1'b1);
    checkValue("hold_lost", 32'(state), 32'd0);

    // Dropping sync_en while locked forces free-run.
    applyStimulus(1'b1, 1'b1);
    gapFlag(1000, 1'b1);
    gapFlag(1000, 1'b1);
    checkValue("resync_lock", 32'(state), 32'd2);
    idle(1, 1'b0);
    checkValue("sync_off_state", 32'(state), 32'd0);
    checkValue("sync_off_locked", 32'(locked), 32'd0);

    // Randomised flag traffic against the model.
    for (int it = 0; it < 14; it++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 6)       gapFlag(1000 + $urandom_range(0, 16) - 8, 1'b1);
      else if (mode < 8)  gapFlag($urandom_range(1, 1999), 1'b1);
      else if (mode == 8) idle($urandom_range(1000, 2500), 1'b1);
      else                idle($urandom_range(1, 20), 1'b0);
    end

    // Asynchronous reset in the middle of a pulse.
    gapFlag(1000, 1'b1);
    idle(30, 1'b1);
    checkValue("prerst_pulse", 32'(pps_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("async_rst_pulse", 32'(pps_out), 32'd0);
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    idle(1000, 1'b0);
    checkValue("post_rst_first_flag", 32'(pps_flag_out), 32'd1);
    idle(5, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
